// File: rtl/sa_reset_seq_pkg.sv
// Shared types and elaboration helpers for the AUTOSA reset combiner/sequencer.
package sa_reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    // One spare bit so the shared hold/gap counter can never wrap.
    function automatic int cnt_width(input int min_assert, input int release_gap);
        int m;
        m = (min_assert > release_gap) ? min_assert : release_gap;
        return $clog2(m) + 1;
    endfunction

    function automatic bit params_legal(input int num_src, input int num_out,
                                        input int sync_depth, input int min_assert,
                                        input int release_gap);
        return (num_src >= 1) && (num_src <= 8) &&
               (num_out >= 1) && (num_out <= 8) &&
               (sync_depth >= 2) && (min_assert >= 1) && (release_gap >= 1);
    endfunction

endpackage

// File: rtl/sa_reset_sync_n.sv
// Per-source reset synchroniser: async assert, synchronous de-assert, with scan bypass.
module sa_reset_sync_n #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic direct_reset_,
    input  logic test_mode,
    output logic out
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b1};
        end
    end

    assign out = test_mode ? direct_reset_ : sync_q[DEPTH-1];

endmodule

// File: rtl/sa_reset_seq.sv
// Combines synchronised reset sources plus a soft reset, enforces a minimum
// assertion width, then releases the downstream domains one at a time.
module sa_reset_seq
    import sa_reset_seq_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int NUM_OUT     = 3,
    parameter int SYNC_DEPTH  = 2,
    parameter int MIN_ASSERT  = 4,
    parameter int RELEASE_GAP = 2
) (
    input  logic               autosa_clk,
    input  logic               synced_dla_rstn,
    input  logic               direct_reset_,
    input  logic               test_mode,
    input  logic [NUM_SRC-1:0] src_rstn,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rstn_out,
    output logic               seq_busy,
    output logic               all_released,
    output logic [NUM_SRC:0]   last_cause
);

    localparam int CNT_W = cnt_width(MIN_ASSERT, RELEASE_GAP);
    localparam int IDX_W = $clog2(NUM_OUT) + 1;

    if (!params_legal(NUM_SRC, NUM_OUT, SYNC_DEPTH, MIN_ASSERT, RELEASE_GAP)) begin : g_param_check
        $error("sa_reset_seq: parameter out of legal range");
    end

    logic [NUM_SRC-1:0] sync_ok;
    logic [NUM_SRC-1:0] src_clr_n;
    logic               combined_ok;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        assign src_clr_n[i] = src_rstn[i] & synced_dla_rstn;

        sa_reset_sync_n #(
            .DEPTH(SYNC_DEPTH)
        ) u_sync (
            .clk          (autosa_clk),
            .clr_n        (src_clr_n[i]),
            .direct_reset_(direct_reset_),
            .test_mode    (test_mode),
            .out          (sync_ok[i])
        );
    end

    assign combined_ok = &sync_ok;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rstn_q, rstn_d;
    logic [NUM_SRC:0]   cause_q, cause_d;
    logic               sw_pend_q, sw_pend_d;
    logic               ack_q, ack_d;

    // Domains 0..idx are released; higher domains stay in reset.
    function automatic logic [NUM_OUT-1:0] release_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_OUT-1:0] m;
        for (int j = 0; j < NUM_OUT; j++) begin
            m[j] = (IDX_W'(j) <= idx);
        end
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rstn_d    = '0;
        cause_d   = cause_q;
        sw_pend_d = sw_pend_q;
        ack_d     = 1'b0;

        case (state_q)
            ASSERT: begin
                if (combined_ok) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!combined_ok) begin
                    state_d = ASSERT;
                    cause_d = {1'b0, ~sync_ok};
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!combined_ok) begin
                    state_d = ASSERT;
                    cause_d = {1'b0, ~sync_ok};
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    rstn_d = release_mask(idx_q);
                    if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                        state_d = RUN;
                    end else if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                // A hardware drop wins over a coincident soft-reset request.
                if (!combined_ok) begin
                    state_d = ASSERT;
                    cause_d = {1'b0, ~sync_ok};
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (sw_rst_req) begin
                    state_d   = ASSERT;
                    cause_d   = {1'b1, {NUM_SRC{1'b0}}};
                    sw_pend_d = 1'b1;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else begin
                    rstn_d = '1;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        if ((state_d == RUN) && (state_q != RUN) && sw_pend_q) begin
            ack_d     = 1'b1;
            sw_pend_d = 1'b0;
        end
    end

    always_ff @(posedge autosa_clk or negedge synced_dla_rstn) begin
        if (!synced_dla_rstn) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rstn_q    <= '0;
            cause_q   <= '0;
            sw_pend_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rstn_q    <= rstn_d;
            cause_q   <= cause_d;
            sw_pend_q <= sw_pend_d;
            ack_q     <= ack_d;
        end
    end

    assign rstn_out     = test_mode ? {NUM_OUT{direct_reset_}} : rstn_q;
    assign seq_busy     = (state_q != RUN);
    assign all_released = (state_q == RUN);
    assign sw_rst_ack   = ack_q;
    assign last_cause   = cause_q;

endmodule
